man_pixel_stream: RTL and testbench

//  Frame sequencer on the other side of the Mandelbrot compute interface. Issues
//  (px,py) requests in raster order, collects in-order 24-bit colour results in a

---
 rtl/man_pixel_stream_if.sv | 42 ++++
 rtl/man_pixel_stream.sv | 245 ++++++++++++++++++++++++
 tb/tb_man_pixel_stream.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/man_pixel_stream_if.sv
// -----------------------------------------------------------------------------
// man_pixel_stream_if
//  Bundles the three handshake channels around the Mandelbrot frame sequencer:
//   - request channel  : req_valid/req_ready/req_px/req_py  (sequencer -> engine)
//   - response channel : rsp_valid/rsp_ready/rsp_colour     (engine -> sequencer)
//   - video stream     : m_axis_* AXI4-Stream               (sequencer -> VDMA)
//  modport master : the sequencer side (drives requests, accepts responses,
//                   sources the video stream)
//  modport slave  : the environment side (compute engine plus stream sink)
// -----------------------------------------------------------------------------
interface man_pixel_stream_if;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_px;
    logic [8:0]  req_py;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_colour;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tuser;
    logic        m_axis_tlast;

    modport master (
        output req_valid, req_px, req_py,
        input  req_ready,
        input  rsp_valid, rsp_colour,
        output rsp_ready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  req_valid, req_px, req_py,
        output req_ready,
        output rsp_valid, rsp_colour,
        input  rsp_ready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/man_pixel_stream.sv
// -----------------------------------------------------------------------------
// man_pixel_stream
//  Frame sequencer for the Mandelbrot engine. Issues (px,py) requests in raster
//  order, collects the in-order 24-bit colour results in a small FIFO whose free
//  slots are pre-claimed by credits, and emits them as AXI4-Stream video with
//  tuser marking pixel (0,0) and tlast marking the last pixel of each line.
// Ports
//  aclk        clock
//  aresetn     asynchronous active-low reset (deasserted synchronously inside)
//  start       1-cycle pulse, starts a frame when idle
//  continuous  when 1, a new frame follows each completed frame
//  busy        high while issuing or draining a frame
//  bus         request / response / video stream channels (master side)
// -----------------------------------------------------------------------------
module man_pixel_stream #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 continuous,
    output logic                 busy,
    man_pixel_stream_if.master   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [9:0]    X_LAST  = 10'(H_RES - 1);
    localparam logic [8:0]    Y_LAST  = 9'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    logic [1:0]    rst_sync_r;
    logic          rst_n_s;
    state_t        state_r;
    logic [9:0]    px_r;
    logic [8:0]    py_r;
    logic [9:0]    out_x_r;
    logic [8:0]    out_y_r;
    logic [CW-1:0] credits_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [23:0]   mem_r [FIFO_DEPTH];
    logic          rsp_ready_r;

    logic req_valid_s;
    logic req_fire_s;
    logic last_req_s;
    logic tvalid_s;
    logic pop_s;
    logic push_s;
    logic last_beat_s;

    // Reset synchronizer: assertion is immediate, release takes two clock edges.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    // Credits pre-claim FIFO space, so a request is only offered when its result
    // is guaranteed a slot; this is what lets rsp_ready sit at 1.
    assign req_valid_s = (state_r == ST_ISSUE) && (credits_r != {CW{1'b0}});
    assign req_fire_s  = req_valid_s && bus.req_ready;
    assign last_req_s  = (px_r == X_LAST) && (py_r == Y_LAST);
    assign tvalid_s    = (count_r != {CW{1'b0}});
    assign pop_s       = tvalid_s && bus.m_axis_tready;
    // A push into a full FIFO is only legal when a pop frees a slot that cycle.
    assign push_s      = bus.rsp_valid && rsp_ready_r && ((count_r != DEPTH_C) || pop_s);
    assign last_beat_s = pop_s && (out_x_r == X_LAST) && (out_y_r == Y_LAST);

    // Frame sequencing FSM.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (req_fire_s && last_req_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (last_beat_s) begin
                        state_r <= continuous ? ST_ISSUE : ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Request raster counters; wrap to (0,0) after the last pixel of the frame.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            px_r <= 10'd0;
            py_r <= 9'd0;
        end else if (req_fire_s) begin
            if (px_r == X_LAST) begin
                px_r <= 10'd0;
                py_r <= (py_r == Y_LAST) ? 9'd0 : py_r + 9'd1;
            end else begin
                px_r <= px_r + 10'd1;
            end
        end
    end

    // Output raster counters, independent of the request side.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            out_x_r <= 10'd0;
            out_y_r <= 9'd0;
        end else if (pop_s) begin
            if (out_x_r == X_LAST) begin
                out_x_r <= 10'd0;
                out_y_r <= (out_y_r == Y_LAST) ? 9'd0 : out_y_r + 9'd1;
            end else begin
                out_x_r <= out_x_r + 10'd1;
            end
        end
    end

    // Credit counter: claim on request accept, release on stream pop.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            credits_r <= DEPTH_C;
        end else begin
            case ({req_fire_s, pop_s})
                2'b10:   credits_r <= credits_r - ONE_C;
                2'b01:   credits_r <= credits_r + ONE_C;
                default: credits_r <= credits_r;
            endcase
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 24'h000000;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= bus.rsp_colour;
        end
    end

    // Response ready rises one cycle after reset release and then stays high.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rsp_ready_r <= 1'b0;
        end else begin
            rsp_ready_r <= 1'b1;
        end
    end

    // All outputs decode registers only; sideband is gated so idle outputs are 0.
    assign busy              = (state_r != ST_IDLE);
    assign bus.req_valid     = req_valid_s;
    assign bus.req_px        = px_r;
    assign bus.req_py        = py_r;
    assign bus.rsp_ready     = rsp_ready_r;
    assign bus.m_axis_tvalid = tvalid_s;
    assign bus.m_axis_tdata  = tvalid_s ? {8'h00, mem_r[rd_ptr_r]} : 32'h00000000;
    assign bus.m_axis_tuser  = tvalid_s && (out_x_r == 10'd0) && (out_y_r == 9'd0);
    assign bus.m_axis_tlast  = tvalid_s && (out_x_r == X_LAST);

    man_pixel_stream_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_chk (
        .aclk      (aclk),
        .rst_n     (rst_n_s),
        .rsp_valid (bus.rsp_valid),
        .rsp_ready (rsp_ready_r),
        .pop       (pop_s),
        .count     (count_r),
        .credits   (credits_r)
    );
endmodule

// -----------------------------------------------------------------------------
// man_pixel_stream_chk
//  Protocol checks for the sequencer: a response must never arrive while the
//  FIFO is full without a same-cycle pop, and credits never exceed the depth.
// -----------------------------------------------------------------------------
module man_pixel_stream_chk #(
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = 5
) (
    input logic          aclk,
    input logic          rst_n,
    input logic          rsp_valid,
    input logic          rsp_ready,
    input logic          pop,
    input logic [CW-1:0] count,
    input logic [CW-1:0] credits
);
    a_no_overflow: assert property (@(posedge aclk) disable iff (!rst_n)
        !(rsp_valid && rsp_ready && (count == CW'(FIFO_DEPTH)) && !pop));
    a_credit_range: assert property (@(posedge aclk) disable iff (!rst_n)
        credits <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_man_pixel_stream.sv
// -----------------------------------------------------------------------------
// tb_man_pixel_stream
//  Drives man_pixel_stream (4x3 frame, 4-deep FIFO) with a delayed in-order
//  compute engine and a stream sink. Every accepted request gets a random colour;
//  the expected video stream is simply the accepted requests in order, with
//  tuser at (0,0) and tlast at x=H-1.
// -----------------------------------------------------------------------------
module tb_man_pixel_stream;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int D  = 4;
    localparam int FR = H * V;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic busy;

    man_pixel_stream_if bus();

    man_pixel_stream #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .continuous (continuous),
        .busy       (busy),
        .bus        (bus.master)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rr_mode  = 0;   // 0: ready=1, 1: toggle, 2: random
    int tr_mode  = 1;   // 0: tready=0, 1: tready=1, 2: random
    int dly_mode = 0;   // 0: fixed 3-cycle engine, 1: random 1..6

    logic [25:0] exp_q[$];
    logic [23:0] eng_q[$];
    int          eng_due[$];
    int          last_due    = 0;
    int          req_n       = 0;
    int          outstanding = 0;
    int          reqs        = 0;
    int          beats       = 0;
    logic [31:0] tuser_mask  = 32'h0;
    logic [31:0] tlast_mask  = 32'h0;
    logic        prev_stall  = 1'b0;
    logic [9:0]  prev_px     = 10'd0;
    logic [8:0]  prev_py     = 9'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Per-cycle engine, sink and compare process.
    initial begin
        logic [23:0] colour;
        int d;
        int due;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_colour = 24'h0;
        bus.m_axis_tready = 1'b0;
        forever begin
            @(negedge aclk);
            cyc++;
            case (rr_mode)
                0:       bus.req_ready = 1'b1;
                1:       bus.req_ready = ~bus.req_ready;
                default: bus.req_ready = ($urandom_range(0, 3) != 0);
            endcase
            case (tr_mode)
                0:       bus.m_axis_tready = 1'b0;
                1:       bus.m_axis_tready = 1'b1;
                default: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
            if (aresetn && eng_q.size() > 0 && eng_due[0] <= cyc) begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_colour = eng_q.pop_front();
                void'(eng_due.pop_front());
            end else begin
                bus.rsp_valid  = 1'b0;
                bus.rsp_colour = 24'($urandom);
            end
            #1;
            if (aresetn) begin
                if (bus.rsp_valid) chk("rsp_ready", {63'd0, bus.rsp_ready}, 64'd1);
                if (prev_stall)
                    chk("req_hold", {44'd0, bus.req_valid, bus.req_px, bus.req_py},
                        {44'd0, 1'b1, prev_px, prev_py});
                if (bus.req_valid) begin
                    chk("req_busy", {63'd0, busy}, 64'd1);
                    chk("credit_limit", {63'd0, outstanding < D}, 64'd1);
                    chk("req_xy", {45'd0, bus.req_px, bus.req_py},
                        {45'd0, 10'(req_n % H), 9'((req_n / H) % V)});
                    if (bus.req_ready) begin
                        colour = 24'($urandom);
                        exp_q.push_back({(bus.req_px == 10'd0) && (bus.req_py == 9'd0),
                                         bus.req_px == 10'(H - 1), colour});
                        d   = (dly_mode == 0) ? 3 : $urandom_range(1, 6);
                        due = cyc + d;
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        eng_q.push_back(colour);
                        eng_due.push_back(due);
                        req_n++;
                        reqs++;
                        outstanding++;
                    end
                end
                prev_stall = bus.req_valid && !bus.req_ready;
                prev_px    = bus.req_px;
                prev_py    = bus.req_py;
                if (bus.m_axis_tvalid) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 64'd1, 64'd0);
                    end else begin
                        chk("beat", {30'd0, bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata},
                            {30'd0, exp_q[0][25:24], 8'h00, exp_q[0][23:0]});
                        if (bus.m_axis_tready) begin
                            void'(exp_q.pop_front());
                            outstanding--;
                            if (beats < 32) begin
                                tuser_mask[beats] = bus.m_axis_tuser;
                                tlast_mask[beats] = bus.m_axis_tlast;
                            end
                            beats++;
                        end
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic clear_counts();
        beats = 0;
        reqs = 0;
        tuser_mask = 32'h0;
        tlast_mask = 32'h0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        eng_q.delete();
        eng_due.delete();
        last_due = 0;
        req_n = 0;
        outstanding = 0;
    endtask

    task automatic pulse_start();
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int limit);
        int c = 0;
        while (beats < target && c < limit) begin
            @(negedge aclk);
            c++;
        end
        chk("beat_timeout", {63'd0, beats >= target}, 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        bit done = 1'b0;
        while (!done && c < limit) begin
            @(negedge aclk);
            #2;
            c++;
            done = !busy && exp_q.size() == 0 && eng_q.size() == 0;
        end
        chk("idle_timeout", {63'd0, done}, 64'd1);
    endtask

    function automatic logic [63:0] out_vec();
        return {7'd0, busy, bus.req_valid, bus.req_px, bus.req_py, bus.rsp_ready,
                bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
    endfunction

    // Directed scenarios followed by a long randomized continuous run.
    initial begin
        repeat (3) @(negedge aclk);
        #1 chk("reset_outputs", out_vec(), 64'd0);
        @(negedge aclk) aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        #2 chk("idle_after_reset", {60'd0, busy, bus.rsp_ready, bus.req_valid, bus.m_axis_tvalid},
               64'b0100);

        // Single frame, free-flowing.
        clear_counts();
        pulse_start();
        wait_idle(300);
        chk("t1_beats", 64'(beats), 64'd12);
        chk("t1_reqs", 64'(reqs), 64'd12);
        chk("t1_tuser", {32'd0, tuser_mask}, 64'h001);
        chk("t1_tlast", {32'd0, tlast_mask}, 64'h888);

        // Stream blocked: credits cap outstanding requests at the FIFO depth.
        tr_mode = 0;
        clear_counts();
        pulse_start();
        repeat (40) @(negedge aclk);
        #2;
        chk("t2_reqs_blocked", 64'(reqs), 64'd4);
        chk("t2_req_valid_low", {63'd0, bus.req_valid}, 64'd0);
        chk("t2_no_beats", 64'(beats), 64'd0);
        tr_mode = 1;
        wait_idle(300);
        chk("t2_reqs", 64'(reqs), 64'd12);
        chk("t2_beats", 64'(beats), 64'd12);

        // Toggling req_ready.
        rr_mode = 1;
        clear_counts();
        pulse_start();
        wait_idle(400);
        chk("t3_reqs", 64'(reqs), 64'd12);
        chk("t3_beats", 64'(beats), 64'd12);

        // Continuous mode with a stray start pulse mid-frame.
        rr_mode = 0;
        continuous = 1'b1;
        clear_counts();
        pulse_start();
        wait_beats(14, 500);
        pulse_start();
        continuous = 1'b0;
        wait_idle(500);
        chk("t4_beats", 64'(beats), 64'd24);
        chk("t4_tuser", {32'd0, tuser_mask}, 64'h001001);
        chk("t4_tlast", {32'd0, tlast_mask}, 64'h888888);

        // Reset in the middle of a frame.
        clear_counts();
        pulse_start();
        wait_beats(5, 300);
        @(negedge aclk);
        #3 aresetn = 1'b0;
        #1 chk("t5_reset_outputs", out_vec(), 64'd0);
        clear_model();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        clear_counts();
        pulse_start();
        wait_idle(300);
        chk("t5_beats", 64'(beats), 64'd12);
        chk("t5_tuser", {32'd0, tuser_mask}, 64'h001);

        // Randomized handshakes and engine latency, many frames back to back.
        rr_mode = 2;
        tr_mode = 2;
        dly_mode = 1;
        continuous = 1'b1;
        clear_counts();
        pulse_start();
        wait_beats(FR * 500, 60000);
        continuous = 1'b0;
        wait_idle(2000);
        chk("t6_whole_frames", 64'(beats % FR), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
